// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the datapath width, the reset fetch address default, the bubble
// instruction, the fetch FSM state encoding and the skid buffer layout.
package ifu_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

  // addi x0,x0,0: what decode sees when IF/ID holds no real instruction.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [31:0]     insn;
    logic [XLEN-1:0] pc;
  } skid_t;

  // Instructions are word aligned; low address bits of a redirect are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Instruction memory request/response bus.
// master (fetch unit): drives imem_req, imem_addr; receives imem_ready,
//                      imem_rvalid, imem_rdata.
// slave  (memory):     the mirror image.
interface ifu_if #(
  parameter int unsigned XLEN = 64
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/ifu_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_hold            keep current contents (priority over load)
//   i_load            load {i_insn, i_pc} as a valid instruction
//   i_insn, i_pc      word and its PC to load
//   o_insn, o_pc      registered instruction and PC
//   o_valid           register holds a real instruction
// With neither hold nor load the register becomes a bubble: the previous
// instruction has been consumed by decode.
module ifu_if_id_reg
  import ifu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_hold,
  input  logic            i_load,
  input  logic [31:0]     i_insn,
  input  logic [XLEN-1:0] i_pc,
  output logic [31:0]     o_insn,
  output logic [XLEN-1:0] o_pc,
  output logic            o_valid
);

  logic [31:0]     r_insn;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_insn  <= NOP_INSN;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_hold) begin
      r_insn  <= r_insn;
      r_pc    <= r_pc;
      r_valid <= r_valid;
    end else if (i_load) begin
      r_insn  <= i_insn;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end else begin
      // Bubble keeps the stale PC; only instruction and valid matter.
      r_insn  <= NOP_INSN;
      r_valid <= 1'b0;
    end
  end

  assign o_insn  = r_insn;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/ifu.sv
// Instruction fetch stage.
// Owns the fetch PC, keeps at most one request outstanding on the imem bus,
// parks a returning word in a skid buffer while decode is stalled, and
// drives the IF/ID register. Taken branches/jumps from decode redirect fetch.
// Ports:
//   sys_clk, sys_rst  clock, synchronous active-high reset
//   stall             hold IF/ID this cycle
//   pc_sel            taken redirect for the instruction in IF/ID
//   branch_target     redirect address, valid with pc_sel
//   imem              instruction memory bus (master side)
//   id_instruction    IF/ID instruction
//   id_pc             IF/ID PC
//   id_valid          IF/ID holds a real instruction
module ifu
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            stall,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] branch_target,
  ifu_if.master           imem,
  output logic [31:0]     id_instruction,
  output logic [XLEN-1:0] id_pc,
  output logic            id_valid
);

  ifu_state_e      r_state, w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [XLEN-1:0] r_req_pc, w_req_pc_nxt;
  logic            r_drop, w_drop_nxt;
  skid_t           r_skid, w_skid_nxt;

  logic            w_redirect;
  logic            w_accept;
  logic            w_load;
  logic [31:0]     w_load_insn;
  logic [XLEN-1:0] w_load_pc;
  logic            w_unused_target;

  // Branch operands are not settled during a stall, so pc_sel is ignored then.
  assign w_redirect      = pc_sel && !stall;
  assign w_accept        = (r_state == S_REQ) && imem.imem_ready;
  assign w_unused_target = ^branch_target[1:0];

  assign imem.imem_req  = (r_state == S_REQ);
  assign imem.imem_addr = r_fetch_pc;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_drop     <= 1'b0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_skid     <= w_skid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_drop_nxt     = r_drop;
    w_skid_nxt     = r_skid;
    w_load         = 1'b0;
    w_load_insn    = imem.imem_rdata;
    w_load_pc      = r_req_pc;

    unique case (r_state)
      S_REQ: begin
        if (w_accept) begin
          w_req_pc_nxt = r_fetch_pc;
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else if (stall) begin
            w_skid_nxt.insn = imem.imem_rdata;
            w_skid_nxt.pc   = r_req_pc;
            w_state_nxt     = S_HOLD;
          end else begin
            w_load         = 1'b1;
            w_fetch_pc_nxt = r_req_pc + XLEN'(4);
            w_state_nxt    = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          w_load         = 1'b1;
          w_load_insn    = r_skid.insn;
          w_load_pc      = r_skid.pc;
          w_fetch_pc_nxt = r_skid.pc + XLEN'(4);
          w_state_nxt    = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase

    // A redirect overrides everything above. A request already in flight (or
    // accepted this cycle) must still return, so wait for it and drop it.
    if (w_redirect) begin
      w_fetch_pc_nxt = align_pc(branch_target);
      w_load         = 1'b0;
      w_skid_nxt     = '0;
      w_drop_nxt     = 1'b0;
      w_state_nxt    = S_REQ;
      if ((r_state == S_WAIT) && !imem.imem_rvalid) begin
        w_state_nxt = S_WAIT;
        w_drop_nxt  = 1'b1;
      end else if (w_accept) begin
        w_state_nxt = S_WAIT;
        w_drop_nxt  = 1'b1;
      end
    end
  end

  ifu_if_id_reg u_if_id_reg (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_hold  (stall),
    .i_load  (w_load),
    .i_insn  (w_load_insn),
    .i_pc    (w_load_pc),
    .o_insn  (id_instruction),
    .o_pc    (id_pc),
    .o_valid (id_valid)
  );

endmodule

// File: tb/tb_ifu.sv
// Directed testbench for the instruction fetch unit.
module tb_ifu;
  import ifu_pkg::*;

  logic            clk;
  logic            rst;
  logic            stall;
  logic            pc_sel;
  logic [XLEN-1:0] branch_target;
  logic [31:0]     id_instruction;
  logic [XLEN-1:0] id_pc;
  logic            id_valid;

  int checks;
  int errors;

  ifu_if #(.XLEN(XLEN)) imem_bus ();

  ifu #(.RESET_PC(64'h8000_0000)) dut (
    .sys_clk        (clk),
    .sys_rst        (rst),
    .stall          (stall),
    .pc_sel         (pc_sel),
    .branch_target  (branch_target),
    .imem           (imem_bus),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .id_valid       (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are changed and outputs
  // sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; pc_sel = 1'b0; branch_target = '0;
    imem_bus.imem_ready = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %0b want 0", id_valid); end
    checks++; if (id_instruction !== 32'h0000_0013) begin errors++;
      $display("FAIL reset_insn: got %h want 00000013", id_instruction); end
    checks++; if (id_pc !== 64'h0) begin errors++;
      $display("FAIL reset_pc: got %h want 0", id_pc); end
    checks++; if (imem_bus.imem_req !== 1'b1) begin errors++;
      $display("FAIL reset_req: got %0b want 1", imem_bus.imem_req); end
    checks++; if (imem_bus.imem_addr !== 64'h8000_0000) begin errors++;
      $display("FAIL reset_addr: got %h want 80000000", imem_bus.imem_addr); end
  endtask

  task automatic test_first_fetch();
    imem_bus.imem_ready = 1'b1;
    tick();
    imem_bus.imem_ready = 1'b0;
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++;
      $display("FAIL first_wait_req: got %0b want 0", imem_bus.imem_req); end
    checks++; if (id_valid !== 1'b0) begin errors++;
      $display("FAIL first_early_valid: got %0b want 0", id_valid); end
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h0050_0093;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    checks++; if (id_valid !== 1'b1) begin errors++;
      $display("FAIL first_valid: got %0b want 1", id_valid); end
    checks++; if (id_pc !== 64'h8000_0000) begin errors++;
      $display("FAIL first_pc: got %h want 80000000", id_pc); end
    checks++; if (id_instruction !== 32'h0050_0093) begin errors++;
      $display("FAIL first_insn: got %h want 00500093", id_instruction); end
    checks++; if (imem_bus.imem_addr !== 64'h8000_0004 || imem_bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL first_next_addr: got %h req %0b want 80000004 req 1",
               imem_bus.imem_addr, imem_bus.imem_req); end
  endtask

  task automatic test_stall_skid();
    // Stall from the accept edge so the previous word stays in IF/ID.
    stall = 1'b1; imem_bus.imem_ready = 1'b1;
    tick();
    imem_bus.imem_ready = 1'b0;
    checks++; if (id_valid !== 1'b1 || id_instruction !== 32'h0050_0093) begin errors++;
      $display("FAIL stall_hold_accept: got %0b/%h want 1/00500093", id_valid, id_instruction);
    end
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h00a0_0113;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    checks++; if (id_instruction !== 32'h0050_0093 || id_pc !== 64'h8000_0000) begin errors++;
      $display("FAIL stall_ifid_held: got %h/%h want 00500093/80000000", id_instruction, id_pc);
    end
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++;
      $display("FAIL hold_req: got %0b want 0", imem_bus.imem_req); end
    tick();
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++;
      $display("FAIL hold_req2: got %0b want 0", imem_bus.imem_req); end
    stall = 1'b0;
    tick();
    checks++; if (id_instruction !== 32'h00a0_0113 || id_valid !== 1'b1) begin errors++;
      $display("FAIL skid_insn: got %h/%0b want 00a00113/1", id_instruction, id_valid); end
    checks++; if (id_pc !== 64'h8000_0004) begin errors++;
      $display("FAIL skid_pc: got %h want 80000004", id_pc); end
    checks++; if (imem_bus.imem_addr !== 64'h8000_0008 || imem_bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL skid_next_addr: got %h req %0b want 80000008 req 1",
               imem_bus.imem_addr, imem_bus.imem_req); end
  endtask

  task automatic test_redirect_wait();
    imem_bus.imem_ready = 1'b1;
    tick();
    imem_bus.imem_ready = 1'b0;
    pc_sel = 1'b1; branch_target = 64'h8000_0100;
    tick();
    pc_sel = 1'b0;
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++;
      $display("FAIL redir_wait_req: got %0b want 0", imem_bus.imem_req); end
    tick();
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hdead_beef;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    checks++; if (id_valid !== 1'b0 || id_instruction !== 32'h0000_0013) begin errors++;
      $display("FAIL redir_drop: got %0b/%h want 0/00000013", id_valid, id_instruction); end
    checks++; if (imem_bus.imem_addr !== 64'h8000_0100 || imem_bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL redir_addr: got %h req %0b want 80000100 req 1",
               imem_bus.imem_addr, imem_bus.imem_req); end
  endtask

  task automatic test_pcsel_stalled();
    imem_bus.imem_ready = 1'b1;
    tick();
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h0010_0193;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    checks++; if (id_pc !== 64'h8000_0100 || id_valid !== 1'b1) begin errors++;
      $display("FAIL target_fetch: got %h/%0b want 80000100/1", id_pc, id_valid); end
    stall = 1'b1; pc_sel = 1'b1; branch_target = 64'h8000_0400;
    tick();
    checks++; if (id_valid !== 1'b1 || id_instruction !== 32'h0010_0193) begin errors++;
      $display("FAIL pcsel_stall_held: got %0b/%h want 1/00100193", id_valid, id_instruction);
    end
    checks++; if (imem_bus.imem_addr !== 64'h8000_0104) begin errors++;
      $display("FAIL pcsel_stall_pc: got %h want 80000104", imem_bus.imem_addr); end
    stall = 1'b0; pc_sel = 1'b0;
    tick();
    checks++; if (id_valid !== 1'b0 || id_instruction !== 32'h0000_0013) begin errors++;
      $display("FAIL consumed_bubble: got %0b/%h want 0/00000013", id_valid, id_instruction); end
  endtask

  task automatic test_reset_in_hold();
    imem_bus.imem_ready = 1'b1;
    tick();
    imem_bus.imem_ready = 1'b0;
    stall = 1'b1;
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h0020_0213;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++;
      $display("FAIL rst_hold_req: got %0b want 0", imem_bus.imem_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0;
    checks++; if (id_valid !== 1'b0 || id_instruction !== 32'h0000_0013) begin errors++;
      $display("FAIL rst_hold_ifid: got %0b/%h want 0/00000013", id_valid, id_instruction); end
    checks++; if (imem_bus.imem_addr !== 64'h8000_0000 || imem_bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold_addr: got %h req %0b want 80000000 req 1",
               imem_bus.imem_addr, imem_bus.imem_req); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++;
      $display("FAIL rst_skid_cleared: got %0b want 0", id_valid); end
  endtask

  task automatic test_redirect_align();
    pc_sel = 1'b1; branch_target = 64'h8000_0102;
    tick();
    pc_sel = 1'b0;
    checks++; if (imem_bus.imem_addr !== 64'h8000_0100) begin errors++;
      $display("FAIL align_addr: got %h want 80000100", imem_bus.imem_addr); end
    // Redirect in the same cycle the request is accepted.
    pc_sel = 1'b1; branch_target = 64'h8000_0200; imem_bus.imem_ready = 1'b1;
    tick();
    pc_sel = 1'b0; imem_bus.imem_ready = 1'b0;
    checks++; if (imem_bus.imem_req !== 1'b0) begin errors++;
      $display("FAIL accept_redir_req: got %0b want 0", imem_bus.imem_req); end
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h1234_5678;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++;
      $display("FAIL accept_redir_drop: got %0b want 0", id_valid); end
    checks++; if (imem_bus.imem_addr !== 64'h8000_0200 || imem_bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL accept_redir_addr: got %h req %0b want 80000200 req 1",
               imem_bus.imem_addr, imem_bus.imem_req); end
  endtask

  task automatic test_wrap();
    pc_sel = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    pc_sel = 1'b0;
    checks++; if (imem_bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++;
      $display("FAIL wrap_target: got %h want fffffffffffffffc", imem_bus.imem_addr); end
    imem_bus.imem_ready = 1'b1;
    tick();
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h0000_0073;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    checks++; if (id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || id_valid !== 1'b1) begin errors++;
      $display("FAIL wrap_id_pc: got %h/%0b want fffffffffffffffc/1", id_pc, id_valid); end
    checks++; if (imem_bus.imem_addr !== 64'h0) begin errors++;
      $display("FAIL wrap_addr: got %h want 0", imem_bus.imem_addr); end
  endtask

  task automatic test_back_to_back();
    // ready held high; each response arrives one cycle after acceptance.
    imem_bus.imem_ready = 1'b1;
    tick();
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h0030_0293;
    tick();
    imem_bus.imem_rvalid = 1'b0;
    checks++; if (id_pc !== 64'h0 || id_instruction !== 32'h0030_0293 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got %h/%h/%0b want 0/00300293/1", id_pc, id_instruction,
               id_valid); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++;
      $display("FAIL b2b_gap: got %0b want 0", id_valid); end
    imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h0040_0313;
    tick();
    imem_bus.imem_rvalid = 1'b0; imem_bus.imem_ready = 1'b0;
    checks++; if (id_pc !== 64'h4 || id_instruction !== 32'h0040_0313 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got %h/%h/%0b want 4/00400313/1", id_pc, id_instruction,
               id_valid); end
    checks++; if (imem_bus.imem_addr !== 64'h8) begin errors++;
      $display("FAIL b2b_next_addr: got %h want 8", imem_bus.imem_addr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_fetch();
    test_stall_skid();
    test_redirect_wait();
    test_pcsel_stalled();
    test_reset_in_hold();
    test_redirect_align();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
Instruction fetch stage of the five-stage RV64 pipeline. Owns the fetch PC, issues one outstanding request at a time to instruction memory, and buffers a returning word when decode is stalled. Drives the IF/ID pipeline register (instruction, PC, valid) that feeds the decode stage. Takes taken-jump/branch redirects (pc_sel, target) back from decode.

Parameters:
XLEN, 64, PC and target width
RESET_PC, 64'h8000_0000, first fetch address after reset
NOP_INSN, 32'h0000_0013, addi x0,x0,0 placed in IF/ID when invalid

Ports:
sys_clk  in  1  clock; all state updates on its rising edge
sys_rst  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold IF/ID contents this cycle
pc_sel  in  1  decode: taken jump/branch for instruction in IF/ID
branch_target  in  XLEN  redirect address, valid with pc_sel
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address, stable while imem_req high
imem_ready  in  1  memory accepts request when req&&ready
imem_rvalid  in  1  response word valid (>=1 cycle after acceptance)
imem_rdata  in  32  response instruction word
id_instruction  out  32  IF/ID register: instruction to decode
id_pc  out  XLEN  IF/ID register: PC of id_instruction (decode now_pc)
id_valid  out  1  IF/ID register holds a real instruction

Behaviour:
- Registers: fetch_pc, req_pc (address of outstanding request), drop flag, skid buffer {insn, pc}, state, IF/ID {id_instruction, id_pc, id_valid}.
- Reset (sys_rst high at edge, any state): fetch_pc=RESET_PC, state=S_REQ, drop=0, id_valid=0, id_instruction=NOP_INSN, id_pc=0, skid cleared. Outstanding memory response after reset is ignored (drop not needed: memory is reset together).
- redirect = pc_sel && !stall. pc_sel during stall is ignored (branch operands not yet valid).
- S_REQ: imem_req=1, imem_addr=fetch_pc. On req&&ready: req_pc=fetch_pc, go S_WAIT. imem_req=0 in all other states.
- S_WAIT on imem_rvalid:
  - drop=1: discard word, drop=0, go S_REQ.
  - stall=1: capture {rdata, req_pc} into skid, go S_HOLD.
  - else: IF/ID <= {rdata, req_pc, 1}; fetch_pc=req_pc+4; go S_REQ.
- S_HOLD: when stall=0, IF/ID <= skid contents, valid=1; fetch_pc=skid pc+4; go S_REQ.
- IF/ID when not stalled and no new word loaded this cycle: id_valid=0, id_instruction=NOP_INSN (decode consumed it). When stall=1: IF/ID holds unchanged.
- Redirect (highest priority after reset): fetch_pc=branch_target with bits[1:0] forced to 0; IF/ID <= bubble (NOP_INSN, valid 0); skid discarded; next state S_REQ, except: in S_WAIT with no rvalid this cycle -> stay S_WAIT with drop=1; in S_REQ with req&&ready this cycle -> S_WAIT with drop=1. rvalid in the redirect cycle is discarded.
- Latency: request accepted at edge N, rvalid at N+1 -> id_valid high after edge N+1. Steady state with ready=1, rvalid after 1 cycle: one instruction per 2 cycles.
- fetch_pc wraps modulo 2^XLEN; no alignment fault generated.

Decomposition:
- para.v: RESET_PC default, NOP_INSN, state encodings S_REQ/S_WAIT/S_HOLD (2 bits).
- Sub-module if_id_reg (IF/ID register with load/hold/bubble controls) is natural; FSM, PC and skid stay in ifu.

Test Plan:
- Reset release, ready=1, rvalid 1 cycle later with 32'h00500093 -> first imem_addr=0x80000000; id_pc=0x80000000, id_valid=1; next imem_addr=0x80000004.
- stall high while rvalid returns 32'h00a00113 -> IF/ID unchanged, imem_req=0 in S_HOLD; stall drops -> id_instruction=0x00a00113 next edge, then fetch 0x80000008.
- pc_sel=1, branch_target=0x80000100 while S_WAIT, rvalid arrives 2 cycles later -> word discarded, id_valid=0, next imem_addr=0x80000100.
- pc_sel=1 with stall=1 -> no redirect, fetch_pc unchanged, IF/ID held.
- sys_rst asserted in S_HOLD with skid full -> id_valid=0, id_instruction=0x00000013, imem_addr=0x80000000 next cycle.
- branch_target=0x80000102 -> imem_addr=0x80000100; fetch_pc 0xFFFF_FFFF_FFFF_FFFC +4 -> 0x0.
